mips_fetch_sequencer: RTL

MIPS_FETCH_SEQUENCER -- requirements
Module: mips_fetch_sequencer

---
 rtl/mips_fetch_sequencer.sv | 92 +++++++++
 1 files changed

// File: rtl/mips_fetch_sequencer.sv
// Multicycle MIPS fetch/execute sequencer: FETCH -> EXEC1 -> (EXEC2) -> FETCH, with terminal HALT.
// Holds the instruction and load-data registers and counts retired instructions.
module mips_fetch_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        halt_req,
  input  logic        extra,
  input  logic        is_branch,
  output logic [1:0]  state,
  output logic [31:0] instr,
  output logic [31:0] mem_data,
  output logic        active,
  output logic        delay_slot,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec1 = 2'b01,
    StExec2 = 2'b10,
    StHalt  = 2'b11
  } state_e;

  state_e      state_q;
  logic [31:0] instr_q;
  logic [31:0] mem_data_q;
  logic        active_q;
  logic        delay_slot_q;
  logic [31:0] retired_q;
  // Branch flag captured when a load leaves EXEC1; applied when it completes from EXEC2.
  logic        branch_pend_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StFetch;
      instr_q       <= '0;
      mem_data_q    <= '0;
      active_q      <= 1'b0;
      delay_slot_q  <= 1'b0;
      retired_q     <= '0;
      branch_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (halt_req) begin
            state_q  <= StHalt;
            active_q <= 1'b0;
          end else begin
            active_q <= 1'b1;
            if (!waitrequest) begin
              instr_q <= readdata;
              state_q <= StExec1;
            end
          end
        end
        StExec1: begin
          active_q <= 1'b1;
          if (!waitrequest) begin
            if (extra) begin
              mem_data_q    <= readdata;
              branch_pend_q <= is_branch;
              state_q       <= StExec2;
            end else begin
              delay_slot_q <= is_branch;
              retired_q    <= retired_q + 32'd1;
              state_q      <= StFetch;
            end
          end
        end
        StExec2: begin
          active_q     <= 1'b1;
          delay_slot_q <= branch_pend_q;
          retired_q    <= retired_q + 32'd1;
          state_q      <= StFetch;
        end
        StHalt: begin
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign instr      = instr_q;
  assign mem_data   = mem_data_q;
  assign active     = active_q;
  assign delay_slot = delay_slot_q;
  assign retired    = retired_q;

endmodule
